// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg - shared encodings and helpers for the seg_disp_arb display
// controller.
//   ST_*  : display state reported on o_state (2 bits).
//   PK_*  : kind of request held in the pending register (3 bits).
//   calc_div : prescaler divide ratio from clock and scan rates.
package seg_disp_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENTRY  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam logic [2:0] PK_NONE = 3'd0;
  localparam logic [2:0] PK_ENT  = 3'd1;
  localparam logic [2:0] PK_RES  = 3'd2;
  localparam logic [2:0] PK_ERR  = 3'd3;
  localparam logic [2:0] PK_CLR  = 3'd4;

  // A ratio below 2 cannot produce a one-cycle pulse separated by idle
  // cycles, so it is clamped to 2.
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    int div;
    div = clk_hz / scan_hz;
    if (div < 2) begin
      div = 2;
    end else begin
      div = div;
    end
    return div;
  endfunction

endpackage

// File: rtl/seg_pls_gen.sv
// seg_pls_gen - scan-tick prescaler.
// Counts 0..DIV-1 and wraps; o_pls is a registered one-cycle pulse that is
// first high DIV cycles after reset release and then every DIV cycles.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   o_pls  scan tick, one cycle wide
module seg_pls_gen #(
  parameter int DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_pls
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pls_q, pls_d;

  // Next prescaler count and pulse; the pulse registers the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    pls_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = {W{1'b0}};
      pls_d = 1'b1;
    end else begin
      cnt_d = cnt_q + W'(1);
      pls_d = 1'b0;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= {W{1'b0}};
      pls_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pls_q <= pls_d;
    end
  end

  assign o_pls = pls_q;

endmodule

// File: rtl/seg_disp_arb.sv
// seg_disp_arb - display controller / arbiter in front of the 8-digit
// 7-segment scanner.
// Generates the 1 kHz scan tick, arbitrates keypad-entry and calculator-result
// requests into a single pending slot, and commits the pending value to the
// scanner only on the last tick of an 8-digit scan frame so a frame never
// mixes old and new digits. The scanner's own active-low reset is expected to
// be driven from ~i_rst at the level above, keeping its digit counter aligned
// with fcnt here.
// Optional feature (macro SEG_ERR_TIMEOUT_EN): ERROR auto-clears after
// HOLD_MS scan ticks; without it ERROR stays until replaced.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_ent_vld, i_ent_bcd   keypad-entry strobe and 8-digit BCD value
//   i_res_vld, i_res_bcd   result strobe and 8-digit BCD value
//   i_res_err              result is an error (qualified by i_res_vld)
//   i_clr                  display clear strobe
//   o_pls_1k               scan tick
//   o_bcd8d, o_err         committed value / error flag to the scanner
//   o_state                0 IDLE, 1 ENTRY, 2 RESULT, 3 ERROR
//   o_busy                 a request is waiting for the next frame boundary
module seg_disp_arb
  import seg_disp_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int HOLD_MS = 2000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ent_vld,
  input  logic [31:0] i_ent_bcd,
  input  logic        i_res_vld,
  input  logic [31:0] i_res_bcd,
  input  logic        i_res_err,
  input  logic        i_clr,
  output logic        o_pls_1k,
  output logic [31:0] o_bcd8d,
  output logic        o_err,
  output logic [1:0]  o_state,
  output logic        o_busy
);

  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);

  logic        pls_s;
  logic        boundary_s;
  logic        commit_s;
  logic        to_hit_s;
  logic [2:0]  base_kind_s;

  logic [2:0]  fcnt_q, fcnt_d;
  logic [2:0]  pend_kind_q, pend_kind_d;
  logic [31:0] pend_bcd_q, pend_bcd_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] bcd_q, bcd_d;
  logic        err_q, err_d;

  seg_pls_gen #(.DIV(DIV)) u_pls_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_pls (pls_s)
  );

  // Frame position: the tick with fcnt == 7 is the last digit of the frame.
  always_comb begin
    boundary_s = pls_s && (fcnt_q == 3'd7);
    commit_s   = boundary_s && (pend_kind_q != PK_NONE);
    if (pls_s) begin
      fcnt_d = fcnt_q + 3'd1;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

`ifdef SEG_ERR_TIMEOUT_EN
  localparam logic [15:0] HOLD_CNT = 16'(HOLD_MS);

  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic        to_done_q, to_done_d;

  // Error hold timer: restarts when ERR commits, counts ticks while showing
  // ERROR, and fires once when it reaches HOLD_CNT. A commit in the same
  // cycle already leaves (or re-enters) ERROR, so the timer does not fire.
  always_comb begin
    ms_cnt_d  = ms_cnt_q;
    to_done_d = to_done_q;
    to_hit_s  = 1'b0;
    if (commit_s) begin
      if (pend_kind_q == PK_ERR) begin
        ms_cnt_d  = 16'd0;
        to_done_d = 1'b0;
      end else begin
        ms_cnt_d  = ms_cnt_q;
        to_done_d = to_done_q;
      end
    end else if ((state_q == ST_ERROR) && pls_s && !to_done_q) begin
      ms_cnt_d = ms_cnt_q + 16'd1;
      if ((ms_cnt_q + 16'd1) == HOLD_CNT) begin
        to_done_d = 1'b1;
        to_hit_s  = 1'b1;
      end else begin
        to_done_d = 1'b0;
        to_hit_s  = 1'b0;
      end
    end else begin
      ms_cnt_d  = ms_cnt_q;
      to_done_d = to_done_q;
    end
  end

  // Error hold timer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ms_cnt_q  <= 16'd0;
      to_done_q <= 1'b0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      to_done_q <= to_done_d;
    end
  end
`else
  assign to_hit_s = 1'b0;
`endif

  // Commit and capture. A request seen in the commit cycle starts from an
  // empty slot so it is never folded into the value being committed.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    if (commit_s) begin
      case (pend_kind_q)
        PK_ENT: begin
          state_d = ST_ENTRY;
          bcd_d   = pend_bcd_q;
          err_d   = 1'b0;
        end
        PK_RES: begin
          state_d = ST_RESULT;
          bcd_d   = pend_bcd_q;
          err_d   = 1'b0;
        end
        PK_ERR: begin
          state_d = ST_ERROR;
          bcd_d   = 32'd0;
          err_d   = 1'b1;
        end
        PK_CLR: begin
          state_d = ST_IDLE;
          bcd_d   = 32'd0;
          err_d   = 1'b0;
        end
        default: begin
          state_d = state_q;
          bcd_d   = bcd_q;
          err_d   = err_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (commit_s) begin
      base_kind_s = PK_NONE;
    end else begin
      base_kind_s = pend_kind_q;
    end
    pend_kind_d = base_kind_s;
    pend_bcd_d  = pend_bcd_q;

    // Priority clear > result > entry; a pending clear is never displaced
    // by a result, and an entry only replaces an empty slot or another entry.
    if (i_clr) begin
      pend_kind_d = PK_CLR;
      pend_bcd_d  = 32'd0;
    end else if (i_res_vld) begin
      if (base_kind_s != PK_CLR) begin
        if (i_res_err) begin
          pend_kind_d = PK_ERR;
          pend_bcd_d  = 32'd0;
        end else begin
          pend_kind_d = PK_RES;
          pend_bcd_d  = i_res_bcd;
        end
      end else begin
        pend_kind_d = base_kind_s;
      end
    end else if (i_ent_vld) begin
      if ((base_kind_s == PK_NONE) || (base_kind_s == PK_ENT)) begin
        pend_kind_d = PK_ENT;
        pend_bcd_d  = i_ent_bcd;
      end else begin
        pend_kind_d = base_kind_s;
      end
    end else begin
      pend_kind_d = base_kind_s;
    end

    // The timeout only fills an empty slot; any real request supersedes it.
    if (to_hit_s && (pend_kind_d == PK_NONE)) begin
      pend_kind_d = PK_CLR;
      pend_bcd_d  = 32'd0;
    end else begin
      pend_kind_d = pend_kind_d;
    end
  end

  // Frame counter, pending slot and committed display registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fcnt_q      <= 3'd0;
      pend_kind_q <= PK_NONE;
      pend_bcd_q  <= 32'd0;
      state_q     <= ST_IDLE;
      bcd_q       <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      pend_kind_q <= pend_kind_d;
      pend_bcd_q  <= pend_bcd_d;
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
    end
  end

  assign o_pls_1k = pls_s;
  assign o_bcd8d  = bcd_q;
  assign o_err    = err_q;
  assign o_state  = state_q;
  assign o_busy   = (pend_kind_q != PK_NONE);

endmodule

// File: tb/tb_seg_disp_arb.sv
// tb_seg_disp_arb - self-checking bench for seg_disp_arb with CLK_HZ=8000,
// SCAN_HZ=1000 (DIV=8, 64-cycle frames) and HOLD_MS=4.
// A cycle-number based model predicts every output each cycle; directed
// literal checks pin key points of the scenario.
module tb_seg_disp_arb;

  localparam int DIV   = 8;
  localparam int FRAME = 8 * DIV;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ent_vld = 1'b0;
  logic [31:0] ent_bcd = 32'd0;
  logic        res_vld = 1'b0;
  logic [31:0] res_bcd = 32'd0;
  logic        res_err = 1'b0;
  logic        clr = 1'b0;
  logic        pls_1k;
  logic [31:0] bcd8d;
  logic        err;
  logic [1:0]  state;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Model: c = rising edges since reset release; pending kinds
  // 0 none, 1 entry, 2 result, 3 error, 4 clear.
  int          c = 0;
  int          m_kind = 0;
  logic [31:0] m_pbcd = 32'd0;
  logic [31:0] m_bcd = 32'd0;
  logic        m_err = 1'b0;
  int          m_state = 0;
  int          m_ms = 0;
  bit          m_done = 1'b0;

  seg_disp_arb #(.CLK_HZ(8000), .SCAN_HZ(1000), .HOLD_MS(HOLD)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ent_vld (ent_vld),
    .i_ent_bcd (ent_bcd),
    .i_res_vld (res_vld),
    .i_res_bcd (res_bcd),
    .i_res_err (res_err),
    .i_clr     (clr),
    .o_pls_1k  (pls_1k),
    .o_bcd8d   (bcd8d),
    .o_err     (err),
    .o_state   (state),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t cyc=%0d actual=%h expected=%h", nm, $time, c, act, exp);
    end
  endtask

  task automatic model_step();
    int  cp;
    int  base;
    int  nk;
    bit  commit;
    logic [31:0] nb;
    cp = c;
    commit = (cp > 0) && (cp % FRAME == 0) && (m_kind != 0);
    nk = m_kind;
    nb = m_pbcd;
`ifdef SEG_ERR_TIMEOUT_EN
    if (commit && m_kind == 3) begin
      m_ms = 0;
      m_done = 1'b0;
    end else if (!commit && m_state == 3 && cp > 0 && cp % DIV == 0 && !m_done) begin
      m_ms++;
      if (m_ms == HOLD) m_done = 1'b1;
    end
`endif
    if (commit) begin
      m_state = m_kind == 4 ? 0 : m_kind;
      m_bcd   = (m_kind == 1 || m_kind == 2) ? m_pbcd : 32'd0;
      m_err   = (m_kind == 3);
    end
    base = commit ? 0 : m_kind;
    nk = base;
    if (clr) begin
      nk = 4; nb = 32'd0;
    end else if (res_vld) begin
      if (base != 4) begin
        nk = res_err ? 3 : 2;
        nb = res_err ? 32'd0 : res_bcd;
      end
    end else if (ent_vld) begin
      if (base == 0 || base == 1) begin
        nk = 1; nb = ent_bcd;
      end
    end
`ifdef SEG_ERR_TIMEOUT_EN
    if (!commit && m_done && m_ms == HOLD && cp % DIV == 0 && m_state == 3 && nk == 0) begin
      nk = 4; nb = 32'd0;
      m_ms = HOLD + 1;
    end
`endif
    m_kind = nk;
    m_pbcd = nb;
    c = cp + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        c = 0; m_kind = 0; m_pbcd = 32'd0; m_bcd = 32'd0;
        m_err = 1'b0; m_state = 0; m_ms = 0; m_done = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pls", {31'd0, pls_1k}, (c > 0 && c % DIV == 0) ? 32'd1 : 32'd0);
    chk("bcd", bcd8d, m_bcd);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("state", {30'd0, state}, m_state);
    chk("busy", {31'd0, busy}, (m_kind != 0) ? 32'd1 : 32'd0);
  end

  // Return 2 time units after the edge that makes the cycle count reach n.
  task automatic go_to(input int n);
    int guard;
    guard = 0;
    while (c < n && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (c != n) begin
      checks++;
      failures++;
      $display("FAIL go_to cyc=%0d target=%0d", c, n);
    end
    #1;
  endtask

  task automatic strobe(input bit e, input logic [31:0] eb, input bit r,
                        input logic [31:0] rb, input bit re, input bit cl);
    ent_vld = e; ent_bcd = eb; res_vld = r; res_bcd = rb; res_err = re; clr = cl;
    @(posedge clk);
    #2;
    ent_vld = 1'b0; res_vld = 1'b0; res_err = 1'b0; clr = 1'b0;
  endtask

  function automatic int next_b(input int t);
    return ((t / FRAME) + 1) * FRAME;
  endfunction

  initial begin
    int t;
    int b;
    int b2;
    int b3;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bcd", bcd8d, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    go_to(7);  chk("pls_c7", {31'd0, pls_1k}, 32'd0);
    go_to(8);  chk("pls_c8", {31'd0, pls_1k}, 32'd1);
    go_to(16); chk("pls_c16", {31'd0, pls_1k}, 32'd1);

    go_to(20);
    strobe(1'b1, 32'h0000_0123, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("ent_busy", {31'd0, busy}, 32'd1);
    go_to(64); chk("ent_busy64", {31'd0, busy}, 32'd1);
    chk("ent_state64", {30'd0, state}, 32'd0);
    go_to(65); chk("ent_bcd65", bcd8d, 32'h0000_0123);
    chk("ent_state65", {30'd0, state}, 32'd1);
    chk("ent_busy65", {31'd0, busy}, 32'd0);

    go_to(70);
    strobe(1'b1, 32'h0000_0011, 1'b1, 32'h0000_0456, 1'b0, 1'b0);
    go_to(80);
    strobe(1'b1, 32'h0000_0099, 1'b0, 32'd0, 1'b0, 1'b0);
    go_to(129); chk("res_bcd", bcd8d, 32'h0000_0456);
    chk("res_state", {30'd0, state}, 32'd2);

    go_to(130);
    strobe(1'b0, 32'd0, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0);
    go_to(193); chk("err_state", {30'd0, state}, 32'd3);
    chk("err_flag", {31'd0, err}, 32'd1);
    chk("err_bcd", bcd8d, 32'd0);

`ifdef SEG_ERR_TIMEOUT_EN
    go_to(224); chk("to_busy224", {31'd0, busy}, 32'd0);
    go_to(225); chk("to_busy225", {31'd0, busy}, 32'd1);
    go_to(256); chk("to_state256", {30'd0, state}, 32'd3);
    go_to(257); chk("to_state257", {30'd0, state}, 32'd0);
    chk("to_err257", {31'd0, err}, 32'd0);
`else
    go_to(193 + 100 * FRAME); chk("sticky_state", {30'd0, state}, 32'd3);
    chk("sticky_err", {31'd0, err}, 32'd1);
    go_to(6600);
    strobe(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    go_to(6657); chk("clr_state", {30'd0, state}, 32'd0);
    chk("clr_err", {31'd0, err}, 32'd0);
`endif

    t = c + 6;
    go_to(t);
    strobe(1'b1, 32'h0000_0123, 1'b0, 32'd0, 1'b0, 1'b0);
    b = next_b(t);
    go_to(b + 1); chk("show123", bcd8d, 32'h0000_0123);
    go_to(b + 3);
    strobe(1'b0, 32'd0, 1'b1, 32'h0000_0789, 1'b0, 1'b1);
    b2 = b + FRAME;
    go_to(b2 + 1); chk("clrres_state", {30'd0, state}, 32'd0);
    chk("clrres_bcd", bcd8d, 32'd0);

    t = b2 + 10;
    go_to(t);
    strobe(1'b1, 32'h0000_0042, 1'b0, 32'd0, 1'b0, 1'b0);
    b3 = next_b(t);
    go_to(b3);
    strobe(1'b0, 32'd0, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
    chk("cc_bcd", bcd8d, 32'h0000_0042);
    chk("cc_busy", {31'd0, busy}, 32'd1);
    go_to(b3 + FRAME + 1); chk("cc_bcd2", bcd8d, 32'h0000_0055);
    chk("cc_state2", {30'd0, state}, 32'd2);

    go_to(b3 + FRAME + 6);
    strobe(1'b1, 32'h0000_0077, 1'b0, 32'd0, 1'b0, 1'b0);
    go_to(b3 + FRAME + 20);
    rst = 1'b1;
    #1;
    chk("mrst_bcd", bcd8d, 32'd0);
    chk("mrst_state", {30'd0, state}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    go_to(7);  chk("mrst_pls7", {31'd0, pls_1k}, 32'd0);
    go_to(8);  chk("mrst_pls8", {31'd0, pls_1k}, 32'd1);
    go_to(65); chk("mrst_state65", {30'd0, state}, 32'd0);
    chk("mrst_bcd65", bcd8d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
